// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO: read-mode encodings,
// level-width helper and threshold range clamps.
package fifo_pkg;

    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int level_width(input int a_size);
        return a_size + 1;
    endfunction

    // Out-of-range thresholds are pulled back into 1..depth so the flag never sticks.
    function automatic int clamp_af(input int lvl, input int depth);
        if (lvl < 1)
            return 1;
        else if (lvl > depth)
            return depth;
        else
            return lvl;
    endfunction

    function automatic int clamp_ae(input int lvl, input int depth);
        if (lvl < 0)
            return 0;
        else if (lvl > depth - 1)
            return depth - 1;
        else
            return lvl;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x D_SIZE array, synchronous write, asynchronous read.
module fifo_mem #(
    parameter int D_SIZE = 16,
    parameter int A_SIZE = 3
) (
    input  logic              i_clk,
    input  logic              i_w_en,
    input  logic [A_SIZE-1:0] i_w_addr,
    input  logic [D_SIZE-1:0] i_w_data,
    input  logic [A_SIZE-1:0] i_r_addr,
    output logic [D_SIZE-1:0] o_r_data
);

    localparam int DEPTH = 2 ** A_SIZE;

    logic [D_SIZE-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_w_en)
            mem[i_w_addr] <= i_w_data;
    end

    assign o_r_data = mem[i_r_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered status flags, fill level, sticky error
// flags and either registered or first-word-fall-through read.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int D_SIZE   = 16,
    parameter int A_SIZE   = 3,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_w_inc,
    input  logic [D_SIZE-1:0] i_w_data,
    input  logic              i_r_inc,
    output logic [D_SIZE-1:0] o_r_data,
    output logic              o_r_valid,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_almost_full,
    output logic              o_almost_empty,
    output logic [A_SIZE:0]   o_level,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam int DEPTH = 2 ** A_SIZE;
    localparam int LW    = level_width(A_SIZE);

    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] AF_LVL   = LW'(clamp_af(AF_LEVEL, DEPTH));
    localparam logic [LW-1:0] AE_LVL   = LW'(clamp_ae(AE_LEVEL, DEPTH));

    logic [LW-1:0]     wr_ptr, rd_ptr, level, level_nxt;
    logic              wr_acc, rd_acc;
    logic [D_SIZE-1:0] mem_rd_data;

    // Acceptance uses the registered flags, so a full FIFO never passes a write through.
    assign wr_acc = i_w_inc && !o_full;
    assign rd_acc = i_r_inc && !o_empty;

    always_comb begin
        level_nxt = level;
        case ({wr_acc, rd_acc})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    fifo_mem #(
        .D_SIZE (D_SIZE),
        .A_SIZE (A_SIZE)
    ) u_mem (
        .i_clk    (i_clk),
        .i_w_en   (wr_acc && !i_rst && !i_flush),
        .i_w_addr (wr_ptr[A_SIZE-1:0]),
        .i_w_data (i_w_data),
        .i_r_addr (rd_ptr[A_SIZE-1:0]),
        .o_r_data (mem_rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            o_full         <= 1'b0;
            o_empty        <= 1'b1;
            o_almost_full  <= 1'b0;
            o_almost_empty <= 1'b1;
            o_overflow     <= 1'b0;
            o_underflow    <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc)
                rd_ptr <= rd_ptr + 1'b1;
            level          <= level_nxt;
            o_full         <= (level_nxt == LVL_FULL);
            o_empty        <= (level_nxt == '0);
            o_almost_full  <= (level_nxt >= AF_LVL);
            o_almost_empty <= (level_nxt <= AE_LVL);
            o_overflow     <= o_overflow  || (i_w_inc && o_full);
            o_underflow    <= o_underflow || (i_r_inc && o_empty);
        end
    end

    assign o_level = level;

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            assign o_r_valid = !o_empty;
            assign o_r_data  = o_empty ? '0 : mem_rd_data;
        end else begin : g_reg
            logic [D_SIZE-1:0] r_data_q;
            logic              r_valid_q;

            always_ff @(posedge i_clk) begin
                if (i_rst || i_flush) begin
                    r_data_q  <= '0;
                    r_valid_q <= 1'b0;
                end else begin
                    r_valid_q <= rd_acc;
                    if (rd_acc)
                        r_data_q <= mem_rd_data;
                end
            end

            assign o_r_valid = r_valid_q;
            assign o_r_data  = r_data_q;
        end
    endgenerate

endmodule
